demux_ctrl: RTL and testbench
=============================

Name: demux_ctrl

Overview:
Controller that sequences the 4-way demux. Accepts data words on a valid/ready input stream and selects a destination channel per word, either from an address field or by round-robin over enabled channels. Holds each word in a one-entry output register and drives the demux select and data. Presents per-channel valid/ready handshakes so the downstream consumers can stall.

Parameters:
DW, 4, data word width; matches the demux data path.
NCH, 4, number of output channels; fixed at 4 because select is 2 bits.
CNTW, 8, width of the saturating drop counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
mode  input  1  0 = addressed, 1 = round-robin; sampled only when a word is loaded.
ch_en  input  NCH  per-channel enable mask.
in_valid  input  1  input word valid.
in_ready  output  1  controller can accept the input word this cycle.
in_data  input  DW  input word.
in_dest  input  2  destination channel; used in addressed mode only.
sel  output  2  demux select.
dmx_data  output  DW  data to the demux input.
out_valid  output  NCH  one-hot valid for the selected channel.
out_ready  input  NCH  per-channel consumer ready.
busy  output  1  output register holds a word.
drop_cnt  output  CNTW  saturating count of dropped words.

Behaviour:
- Reset (async, immediate, no clock edge needed): state S_IDLE, sel=0, dmx_data=0, out_valid=0, busy=0, rr_ptr=0, drop_cnt=0. Any held word is lost.
- States:
  - S_IDLE: no word held.
  - S_HOLD: word held; out_valid[sel]=1, all other out_valid bits 0.
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = busy & out_ready[sel].
- in_ready = (!busy | out_fire) & can_route. Combinational from out_ready; full throughput of 1 word/cycle.
- can_route:
  - Addressed mode: always 1.
  - Round-robin mode: |ch_en. If ch_en==0, in_ready=0.
- Latency: a word accepted at edge N drives sel, dmx_data and out_valid from edge N onward (1 cycle).
- sel and dmx_data change only on a load. They are stable while out_valid is high.
- Load, addressed mode:
  - ch_en[in_dest]=1: load word, sel=in_dest, go to S_HOLD.
  - ch_en[in_dest]=0: accept and drop the word; drop_cnt+1, saturating at 2^CNTW-1. No load occurs; the held state changes only through out_fire.
- Load, round-robin mode: pick the first enabled channel at or after rr_ptr, wrapping 3->0. Set sel to that channel and rr_ptr=(pick+1) mod 4. in_dest is ignored.
- rr_ptr is preserved across mode changes and advances only on round-robin loads.
- Transitions:
  - out_fire with in_fire loading a word: stay in S_HOLD with the new word (back-to-back).
  - out_fire without a load: go to S_IDLE, out_valid=0.
  - busy and no out_fire: hold everything; in_ready=0.
- Deasserting ch_en for the channel currently held does not abort; the held word is still delivered.
- out_ready bits of non-selected channels are ignored.
- Simultaneous drop (addressed mode) and out_fire: drop counted, go to S_IDLE.

Decomposition:
- Package demux_pkg:
  - NCH=4, SELW=2.
  - MODE_ADDR=1'b0, MODE_RR=1'b1.
  - state enum {S_IDLE, S_HOLD}.
- Sub-module demux_rr_pick: combinational. Inputs 4-bit mask and 2-bit pointer; outputs 2-bit pick and found flag.
- demux_ctrl instantiates demux_rr_pick. The system top connects sel and dmx_data to the existing demux.

Test Plan:
1. Reset: hold rst_n=0, mode=0 -> sel=0, out_valid=0000, busy=0, drop_cnt=0, in_ready=1. Assert rst_n low mid-S_HOLD -> out_valid=0000 immediately, without a clock edge.
2. Addressed sweep: ch_en=1111, out_ready=1111, in_data=4'b1000, in_dest=0,1,2,3 on consecutive cycles -> sel=0,1,2,3 and out_valid=0001,0010,0100,1000 one cycle after each accept; in_ready stays 1.
3. Backpressure: in_dest=2, out_ready[2]=0 for 3 cycles, second word 4'b0101 pending -> out_valid=0100, sel=2, dmx_data=4'b1000 stable and in_ready=0. Raise out_ready[2] -> both words delivered in order with no bubble.
4. Round-robin: mode=1, ch_en=1011, 5 words -> channels 0,1,3,0,1. Then ch_en=0000 -> in_ready=0 and no word accepted.
5. Drop: mode=0, ch_en=1011, in_dest=2 -> in_ready=1, out_valid stays 0000, drop_cnt increments. 260 drops -> drop_cnt=255.
6. Disable during hold: word held on channel 1, clear ch_en[1] -> out_valid=0010 persists and the word is delivered when out_ready[1]=1.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 4-way demux controller
package demux_pkg;
    localparam int NCH = 4;
    localparam int SELW = 2;
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR = 1'b1;
    typedef enum logic {S_IDLE, S_HOLD} state_t;
endpackage

// File: rtl/demux_ctrl_if.sv
// demux_ctrl_if: input stream, demux drive and per-channel handshake bundle
// Ports (master = environment, slave = controller):
//   mode, ch_en, in_valid, in_data, in_dest, out_ready : master -> slave
//   in_ready, sel, dmx_data, out_valid, busy, drop_cnt : slave -> master
interface demux_ctrl_if import demux_pkg::*; #(parameter int DW = 4, parameter int CNTW = 8);
    logic            mode;
    logic [NCH-1:0]  ch_en;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SELW-1:0] in_dest;
    logic [SELW-1:0] sel;
    logic [DW-1:0]   dmx_data;
    logic [NCH-1:0]  out_valid;
    logic [NCH-1:0]  out_ready;
    logic            busy;
    logic [CNTW-1:0] drop_cnt;
    modport master(output mode, ch_en, in_valid, in_data, in_dest, out_ready,
                   input in_ready, sel, dmx_data, out_valid, busy, drop_cnt);
    modport slave(input mode, ch_en, in_valid, in_data, in_dest, out_ready,
                  output in_ready, sel, dmx_data, out_valid, busy, drop_cnt);
endinterface

// File: rtl/demux_rr_pick.sv
// demux_rr_pick: first set mask bit at or after the pointer, wrapping 3->0
// Ports: i_mask (channel mask), i_ptr (start channel), o_pick (chosen channel), o_found (mask non-empty)
module demux_rr_pick import demux_pkg::*; (
    input  logic [NCH-1:0]  i_mask,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_pick,
    output logic            o_found
);
    // Scanning from the farthest offset down lets the nearest enabled channel win.
    always_comb begin
        o_pick = i_ptr;
        o_found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (i_mask[i_ptr + SELW'(k)]) begin
                o_pick = i_ptr + SELW'(k);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_ctrl.sv
// demux_ctrl: routes stream words to one of four demux channels via a one-entry output register
// Ports: clk, rst_n (async active-low), bus (demux_ctrl_if.slave: input stream, mode/enable,
//        demux select/data, per-channel valid/ready, busy flag, saturating drop counter)
module demux_ctrl import demux_pkg::*; #(
    parameter int DW = 4,
    parameter int CNTW = 8
) (
    input logic         clk,
    input logic         rst_n,
    demux_ctrl_if.slave bus
);
    state_t          r_state;
    state_t          w_next;
    logic [SELW-1:0] r_sel;
    logic [DW-1:0]   r_data;
    logic [SELW-1:0] r_rr_ptr;
    logic [CNTW-1:0] r_drop_cnt;
    logic [SELW-1:0] w_pick;
    logic            w_found;
    logic            w_busy;
    logic            w_out_fire;
    logic            w_can_route;
    logic            w_in_fire;
    logic            w_drop;
    logic            w_load;
    logic            w_rr;

    demux_rr_pick u_pick (
        .i_mask (bus.ch_en),
        .i_ptr  (r_rr_ptr),
        .o_pick (w_pick),
        .o_found(w_found)
    );

    assign w_rr = bus.mode == MODE_RR;
    assign w_busy = r_state == S_HOLD;
    assign w_out_fire = w_busy & bus.out_ready[r_sel];
    assign w_can_route = w_rr ? w_found : 1'b1;
    assign w_in_fire = bus.in_valid & bus.in_ready;
    // Addressed words aimed at a disabled channel are consumed but never loaded.
    assign w_drop = w_in_fire & ~w_rr & ~bus.ch_en[bus.in_dest];
    assign w_load = w_in_fire & ~w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = w_load ? S_HOLD : (w_out_fire ? S_IDLE : r_state);
    end

    always_comb begin
        bus.busy = w_busy;
        bus.in_ready = (~w_busy | w_out_fire) & w_can_route;
        bus.out_valid = w_busy ? ({{(NCH-1){1'b0}}, 1'b1} << r_sel) : '0;
        bus.sel = r_sel;
        bus.dmx_data = r_data;
        bus.drop_cnt = r_drop_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
            r_data <= '0;
            r_rr_ptr <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_load) begin
                r_sel <= w_rr ? w_pick : bus.in_dest;
                r_data <= bus.in_data;
            end
            if (w_load && w_rr) r_rr_ptr <= w_pick + SELW'(1);
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_demux_ctrl.sv
// tb_demux_ctrl: directed vector table, long drop run, random traffic against a reference model, async reset
module tb_demux_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    demux_ctrl_if #(.DW(4), .CNTW(8)) bus ();
    demux_ctrl #(.DW(4), .CNTW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    bit       m_held;
    int       m_ch;
    int       m_sel;
    int       m_data;
    int       m_rr;
    int       m_drop;

    typedef struct {
        logic mode; logic [3:0] en; logic v; logic [3:0] d; logic [1:0] dest; logic [3:0] ordy;
        logic rdy; logic [1:0] sel; logic [3:0] val; logic [3:0] dat; logic busy; logic [7:0] drop;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_ch = 0; m_sel = 0; m_data = 0; m_rr = 0; m_drop = 0;
    endtask

    function automatic bit model_ready();
        bit can = (bus.mode == 1'b0) ? 1'b1 : (bus.ch_en != 4'b0);
        return (!m_held || bus.out_ready[m_ch]) && can;
    endfunction

    task automatic model_edge();
        bit fire_out = m_held && bus.out_ready[m_ch];
        bit fire_in = bus.in_valid && model_ready();
        bit load = 1'b0;
        int tgt = 0;
        if (fire_in) begin
            if (bus.mode == 1'b0) begin
                if (bus.ch_en[bus.in_dest]) begin load = 1'b1; tgt = int'(bus.in_dest); end
                else if (m_drop < 255) m_drop++;
            end else begin
                for (int k = 3; k >= 0; k--)
                    if (bus.ch_en[(m_rr + k) % 4]) tgt = (m_rr + k) % 4;
                load = 1'b1;
                m_rr = (tgt + 1) % 4;
            end
        end
        if (load) begin m_held = 1'b1; m_ch = tgt; m_sel = tgt; m_data = int'(bus.in_data); end
        else if (fire_out) m_held = 1'b0;
    endtask

    task automatic step();
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("sel", 32'(bus.sel), 32'(m_sel));
        chk("dmx_data", 32'(bus.dmx_data), 32'(m_data));
        chk("out_valid", 32'(bus.out_valid), m_held ? (32'd1 << m_ch) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(m_held));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic drive(input logic mode, input logic [3:0] en, input logic v, input logic [3:0] d,
                         input logic [1:0] dest, input logic [3:0] ordy);
        bus.mode = mode; bus.ch_en = en; bus.in_valid = v; bus.in_data = d;
        bus.in_dest = dest; bus.out_ready = ordy;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'hF, 1'b1, 4'h8, 2'd0, 4'hF, 1'b1, 2'd0, 4'b0001, 4'h8, 1'b1, 8'd0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h8, 2'd1, 4'hF, 1'b1, 2'd1, 4'b0010, 4'h8, 1'b1, 8'd0};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h8, 2'd2, 4'hF, 1'b1, 2'd2, 4'b0100, 4'h8, 1'b1, 8'd0};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h8, 2'd3, 4'hF, 1'b1, 2'd3, 4'b1000, 4'h8, 1'b1, 8'd0};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h8, 2'd2, 4'hF, 1'b1, 2'd2, 4'b0100, 4'h8, 1'b1, 8'd0};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h5, 2'd1, 4'hB, 1'b0, 2'd2, 4'b0100, 4'h8, 1'b1, 8'd0};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h5, 2'd1, 4'hF, 1'b1, 2'd1, 4'b0010, 4'h5, 1'b1, 8'd0};
        tbl[9]  = '{1'b0, 4'hF, 1'b0, 4'h5, 2'd1, 4'hF, 1'b1, 2'd1, 4'b0000, 4'h5, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 4'hB, 1'b1, 4'h1, 2'd0, 4'hF, 1'b1, 2'd0, 4'b0001, 4'h1, 1'b1, 8'd0};
        tbl[11] = '{1'b1, 4'hB, 1'b1, 4'h2, 2'd0, 4'hF, 1'b1, 2'd1, 4'b0010, 4'h2, 1'b1, 8'd0};
        tbl[12] = '{1'b1, 4'hB, 1'b1, 4'h3, 2'd0, 4'hF, 1'b1, 2'd3, 4'b1000, 4'h3, 1'b1, 8'd0};
        tbl[13] = '{1'b1, 4'hB, 1'b1, 4'h4, 2'd0, 4'hF, 1'b1, 2'd0, 4'b0001, 4'h4, 1'b1, 8'd0};
        tbl[14] = '{1'b1, 4'hB, 1'b1, 4'h6, 2'd0, 4'hF, 1'b1, 2'd1, 4'b0010, 4'h6, 1'b1, 8'd0};
        tbl[15] = '{1'b1, 4'h0, 1'b1, 4'h7, 2'd0, 4'hF, 1'b0, 2'd1, 4'b0000, 4'h6, 1'b0, 8'd0};
        tbl[16] = tbl[15];
        tbl[17] = '{1'b0, 4'hB, 1'b1, 4'h9, 2'd2, 4'hF, 1'b1, 2'd1, 4'b0000, 4'h6, 1'b0, 8'd1};
        tbl[18] = '{1'b0, 4'hF, 1'b1, 4'hA, 2'd1, 4'hD, 1'b1, 2'd1, 4'b0010, 4'hA, 1'b1, 8'd1};
        tbl[19] = '{1'b0, 4'hD, 1'b0, 4'hA, 2'd1, 4'hD, 1'b0, 2'd1, 4'b0010, 4'hA, 1'b1, 8'd1};
        tbl[20] = '{1'b0, 4'hD, 1'b0, 4'hA, 2'd1, 4'hF, 1'b1, 2'd1, 4'b0000, 4'hA, 1'b0, 8'd1};

        model_reset();
        drive(1'b0, 4'hF, 1'b0, 4'h0, 2'd0, 4'h0);
        #3;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst sel", 32'(bus.sel), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst drop_cnt", 32'(bus.drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].mode, tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].dest, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            #0;
            step();
            chk($sformatf("vec%0d sel", i), 32'(bus.sel), 32'(tbl[i].sel));
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].val));
            chk($sformatf("vec%0d dmx_data", i), 32'(bus.dmx_data), 32'(tbl[i].dat));
            chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d drop_cnt", i), 32'(bus.drop_cnt), 32'(tbl[i].drop));
            #(-0);
        end

        drive(1'b0, 4'hB, 1'b1, 4'h3, 2'd2, 4'hF);
        for (int i = 0; i < 260; i++) step();
        chk("drop saturated", 32'(bus.drop_cnt), 32'd255);
        chk("drop no valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)));
            step();
        end

        drive(1'b0, 4'hF, 1'b1, 4'hC, 2'd3, 4'h0);
        step();
        drive(1'b0, 4'hF, 1'b0, 4'hC, 2'd3, 4'h0);
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'b1000);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst busy", 32'(bus.busy), 32'd0);
        chk("async rst sel", 32'(bus.sel), 32'd0);
        chk("async rst dmx_data", 32'(bus.dmx_data), 32'd0);
        chk("async rst drop_cnt", 32'(bus.drop_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
